// File: rtl/proc_mem_responder.sv
// proc_mem_responder: memory side of the single-cycle processor bus.
// Provides combinational instruction fetch, a word-addressed data RAM,
// a memory-mapped output FIFO with a valid/ready drain, a status word
// and a free-running cycle counter.
module proc_mem_responder #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   pc,
  output logic [31:0]                   instruction,
  input  logic                          mem_write,
  input  logic [31:0]                   alu_result,
  input  logic [31:0]                   write_data,
  output logic [31:0]                   read_data,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam int PAW = $clog2(FIFO_DEPTH);
  localparam int CW  = PAW + 1;

  // Word indices (byte address >> 2) of the memory-mapped registers.
  localparam logic [29:0] FIFO_WORD = 30'h400;
  localparam logic [29:0] STAT_WORD = 30'h401;
  localparam logic [29:0] CYC_WORD  = 30'h402;

  logic [31:0]    imem_q [IMEM_WORDS];
  logic [31:0]    dmem_q [DMEM_WORDS];
  logic [31:0]    fifo_q [FIFO_DEPTH];

  logic [PAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    cycle_q, cycle_d;

  logic [29:0]    pc_word;
  logic [29:0]    d_word;
  logic           dmem_hit, fifo_hit, stat_hit, cyc_hit;
  logic           fifo_full, fifo_empty;
  logic           push_req, push_ok, pop;
  logic [31:0]    status;
  logic           unused_addr_bits;

  // Byte-offset bits never take part in decoding.
  assign unused_addr_bits = ^{pc[1:0], alu_result[1:0]};

  assign pc_word = pc[31:2];
  assign d_word  = alu_result[31:2];

  assign dmem_hit = (d_word < 30'(DMEM_WORDS));
  assign fifo_hit = (d_word == FIFO_WORD);
  assign stat_hit = (d_word == STAT_WORD);
  assign cyc_hit  = (d_word == CYC_WORD);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign status = {24'h0, 4'(count_q), 1'b0, ovf_q, fifo_empty, fifo_full};

  // Fetch is a plain combinational lookup; words beyond the array read as zero.
  assign instruction = (pc_word < 30'(IMEM_WORDS)) ? imem_q[pc[IAW+1:2]] : 32'h0;

  // Drain port comes from registered state only, so a store never bypasses.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_q[rd_ptr_q];

  // Load data mux; the FIFO data port and unmapped space read as zero.
  always_comb begin
    read_data = 32'h0;
    if (dmem_hit) begin
      read_data = dmem_q[alu_result[DAW+1:2]];
    end else if (stat_hit) begin
      read_data = status;
    end else if (cyc_hit) begin
      read_data = cycle_q;
    end
  end

  // Next-state for FIFO bookkeeping, overflow flag and cycle counter.
  always_comb begin
    push_req = mem_write && fifo_hit;
    push_ok  = push_req && !fifo_full;
    pop      = !fifo_empty && out_ready;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cycle_d  = cycle_q + 32'd1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PAW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PAW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Fullness is judged before the edge: a drop still flags even if a pop frees a slot.
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (mem_write && stat_hit) begin
      ovf_d = 1'b0;
    end

    if (mem_write && cyc_hit) begin
      cycle_d = 32'h0;
    end
  end

  // Control registers and FIFO storage; reset also clears the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= 32'h0;
      fifo_q[0] <= 32'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= write_data;
      end
    end
  end

  // Data RAM store; contents survive reset but a store in the reset cycle is blocked.
  always_ff @(posedge clk) begin
    if (!rst && mem_write && dmem_hit) begin
      dmem_q[alu_result[DAW+1:2]] <= write_data;
    end
  end

  // Program load works in any cycle, reset included.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Memory-side counterpart of the single-cycle processor's bus: drives `instruction` from `pc`, and answers `mem_write`/`alu_result`/`write_data` with `read_data`.
- Contains:
  - instruction memory, loaded through a program port;
  - word-addressed data RAM;
  - memory-mapped output FIFO with a valid/ready drain port;
  - status register and free-running cycle counter.
- Sits beside `processor` at top level, replacing bench-driven stimulus.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of 2)
- DMEM_WORDS, 64, data RAM depth in 32-bit words (power of 2)
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- pc  input  32  processor fetch byte address
- instruction  output  32  fetched instruction word
- mem_write  input  1  processor store strobe
- alu_result  input  32  processor data byte address
- write_data  input  32  processor store data
- read_data  output  32  load data returned to processor
- prog_we  input  1  instruction memory load strobe
- prog_addr  input  $clog2(IMEM_WORDS)  instruction word index to load
- prog_data  input  32  instruction word to load
- out_data  output  32  FIFO head word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Address decoding:
  - Addresses are byte addresses; bits [1:0] are ignored everywhere.
  - Word index = addr[31:2].
- Instruction fetch:
  - `instruction` = imem[pc[31:2]] combinationally, same cycle.
  - pc word index >= IMEM_WORDS returns 32'h0.
- Program port:
  - `prog_we` high writes `prog_data` to imem[`prog_addr`] at the clock edge.
  - Allowed any cycle, including during `rst`.
  - A fetch of the same word in that cycle returns the old value.
- Memory contents and reset:
  - imem and data RAM are not cleared by `rst`.
  - Neither memory has a defined power-up value; the bench loads before use.
- Data map, read (combinational, same cycle):
  - 0x0000_0000 .. DMEM_WORDS*4-1: data RAM.
  - 0x0000_1000: FIFO data port, reads 0.
  - 0x0000_1004: status. bit0 = full, bit1 = empty, bit2 = overflow (sticky), bits[7:4] = occupancy count, all other bits 0.
  - 0x0000_1008: cycle counter.
  - Any other address reads 0.
- Data map, write (when `mem_write` = 1, at the clock edge):
  - RAM range: store `write_data`. Read-during-write at the same address returns old data; the new data is visible the next cycle.
  - 0x1000: push `write_data` into the FIFO.
  - 0x1004: clear overflow; other bits are read-only.
  - 0x1008: counter loads 0; `write_data` is ignored.
  - Unmapped address: write ignored, no side effect.
- FIFO:
  - Circular buffer with read/write pointers and a count register.
  - `out_valid` = (count != 0); `out_data` = entry at the read pointer. Both derive from registered state only, with no combinational path from `mem_write`.
  - Pop when `out_valid` && `out_ready`.
  - Push is accepted when count < FIFO_DEPTH, evaluated on pre-edge state. A push while full is dropped and sets overflow, even if a pop occurs the same cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Push into empty: `out_valid` rises the following cycle; no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Cycle counter:
  - 32-bit, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
  - A write to 0x1008 takes priority over the increment: the counter reads 0 the next cycle, then continues 1, 2, ...
- Reset values (`rst` = 1 at edge):
  - FIFO pointers and count = 0, so `out_valid` = 0 and `out_data` = 0 (the head slot is cleared at reset).
  - overflow = 0; counter = 0.
  - `read_data` and `instruction` remain combinational from memory and registers.
  - Reset overrides any store, push or pop in the same cycle.
  - Reset mid-drain discards FIFO contents.

Test Plan:
1. Program load and fetch: `prog_we` writes 32'hE3A0C805 at index 0 and 32'hE3A0100A at index 1. pc = 0 -> `instruction` = 32'hE3A0C805; pc = 4 -> 32'hE3A0100A; pc = 4*IMEM_WORDS -> 0.
2. RAM store/load: store 32'h007E7E00 to 0x10. Same cycle, `read_data` shows old value; next cycle, `read_data` at 0x10 = 32'h007E7E00, and at 0x13 is the same word. Load 0x2000 -> 0.
3. FIFO fill and drain: `out_ready` = 0, push 1..8.
   - Status = 0x81 (count 8, full).
   - 9th push dropped; status = 0x85.
   - Write 0x1004 -> status = 0x81.
   - Raise `out_ready`: `out_data` sequence 1..8 on consecutive cycles, then `out_valid` = 0 and status = 0x02.
4. Simultaneous push/pop at count 3 with `out_ready` = 1: count stays 3, order preserved.
   - Push while full with `out_ready` = 1: pop occurs, push dropped, overflow = 1, count 7.
5. Counter: after reset, reads 0, 1, 2 on successive cycles. Write 0x1008 at value 57 -> next cycle 0.
   - Force (bench-backdoor) 32'hFFFF_FFFF -> next cycle 0.
6. Reset mid-operation: FIFO holds 5 entries plus a store pending in the `rst` cycle. After the edge: `out_valid` = 0, status = 0x02, counter = 0, RAM word unchanged by the blocked store.
